// File: rtl/alu_pkg.sv
// Shared opcode encoding and flag bit positions for the execution-unit ALU.
// Flag vector layout is {N,V,C,Z}; the FLAG_* constants give each bit index.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_AND  = 4'b0011,
    OP_OR   = 4'b0100,
    OP_XOR  = 4'b0101,
    OP_INC  = 4'b0110,
    OP_DEC  = 4'b0111,
    OP_NOT  = 4'b1000,
    OP_NEG  = 4'b1001,
    OP_SHR  = 4'b1010,
    OP_SHL  = 4'b1011,
    OP_ROR  = 4'b1100,
    OP_ROL  = 4'b1101,
    OP_RSV0 = 4'b1110,
    OP_RSV1 = 4'b1111
  } alu_op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  // Reserved opcodes force both result and flags to zero.
  function automatic logic is_reserved(input alu_op_e op);
    return (op == OP_RSV0) || (op == OP_RSV1);
  endfunction

endpackage

// File: rtl/alu_if.sv
// Operation/result bundle of the ALU: the master issues opcodes and operands,
// the slave (the ALU) returns the registered result, flags and out_valid.
interface alu_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output in_valid,
    output opcode,
    output operandA,
    output operandB,
    input  out_valid,
    input  result,
    input  flags
  );

  modport slave (
    input  in_valid,
    input  opcode,
    input  operandA,
    input  operandB,
    output out_valid,
    output result,
    output flags
  );

endinterface

// File: rtl/alu_shifter.sv
// Combinational SHR/SHL/ROR/ROL unit. The shifted-out bit port only exists
// when ALU_FLAGS_EN is defined, since it feeds nothing but the carry flag.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] shifted
`ifdef ALU_FLAGS_EN
  ,
  output logic             out_bit
`endif
);

  always_comb begin
    shifted = '0;
    case (op)
      OP_SHR:  shifted = {1'b0, value[WIDTH-1:1]};
      OP_SHL:  shifted = {value[WIDTH-2:0], 1'b0};
      OP_ROR:  shifted = {value[0], value[WIDTH-1:1]};
      OP_ROL:  shifted = {value[WIDTH-2:0], value[WIDTH-1]};
      default: shifted = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  // Right moves drop the LSB, left moves drop the MSB.
  assign out_bit = ((op == OP_SHR) || (op == OP_ROR)) ? value[0] :
                   ((op == OP_SHL) || (op == OP_ROL)) ? value[WIDTH-1] : 1'b0;
`endif

endmodule

// File: rtl/alu_core.sv
// 16-opcode ALU with a one-cycle registered output stage.
// Define ALU_FLAGS_EN to build the {N,V,C,Z} flag logic; otherwise flags read 0.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  alu_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  alu_op_e          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] next_result;
  logic [WIDTH-1:0] result_q;
  logic             out_valid_q;

  assign op = alu_op_e'(bus.opcode);
  assign a  = bus.operandA;
  assign b  = bus.operandB;

`ifdef ALU_FLAGS_EN
  logic shift_out;
`endif

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .op      (op),
    .value   (a),
    .shifted (shifted)
`ifdef ALU_FLAGS_EN
    ,
    .out_bit (shift_out)
`endif
  );

  always_comb begin
    next_result = '0;
    case (op)
      OP_ADD:  next_result = a + b;
      OP_SUB:  next_result = a - b;
      OP_AND:  next_result = a & b;
      OP_OR:   next_result = a | b;
      OP_XOR:  next_result = a ^ b;
      OP_INC:  next_result = a + ONE;
      OP_DEC:  next_result = a - ONE;
      OP_NOT:  next_result = ~a;
      OP_NEG:  next_result = '0 - a;
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: next_result = shifted;
      default: next_result = '0;
    endcase
  end

  // Idle cycles keep the last result visible while out_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        result_q <= next_result;
      end
    end
  end

  assign bus.result    = result_q;
  assign bus.out_valid = out_valid_q;

`ifdef ALU_FLAGS_EN
  logic       carry;
  logic       ovf;
  logic       a_msb;
  logic       b_msb;
  logic       r_msb;
  logic [3:0] next_flags;
  logic [3:0] flags_q;

  assign a_msb = a[WIDTH-1];
  assign b_msb = b[WIDTH-1];
  assign r_msb = next_result[WIDTH-1];

  // Carry is derived from sign bits so no widened adder is needed.
  always_comb begin
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        carry = (a_msb & b_msb) | ((a_msb | b_msb) & ~r_msb);
        ovf   = (a_msb == b_msb) && (r_msb != a_msb);
      end
      OP_SUB: begin
        carry = (a < b);
        ovf   = (a_msb != b_msb) && (r_msb != a_msb);
      end
      OP_INC: begin
        carry = (a == '1);
        ovf   = ~a_msb & r_msb;
      end
      OP_DEC: begin
        carry = (a == '0);
        ovf   = a_msb & ~r_msb;
      end
      OP_NEG: begin
        carry = (a != '0);
        ovf   = a_msb & r_msb;
      end
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: carry = shift_out;
      default: begin
        carry = 1'b0;
        ovf   = 1'b0;
      end
    endcase
  end

  always_comb begin
    next_flags = '0;
    if (!is_reserved(op)) begin
      next_flags[FLAG_Z] = (next_result == '0);
      next_flags[FLAG_N] = r_msb;
      next_flags[FLAG_C] = carry;
      next_flags[FLAG_V] = ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (bus.in_valid) begin
      flags_q <= next_flags;
    end
  end

  assign bus.flags = flags_q;
`else
  assign bus.flags = '0;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed spec cases, mid-stream reset and a
// randomized run against an arithmetic reference model. Honours ALU_FLAGS_EN.
module tb_alu_core;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_if #(.WIDTH(8)) bus ();

  alu_core #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_result;
  logic [3:0] exp_flags;

  // Reference model from plain integer arithmetic; returns {result, N,V,C,Z}.
  function automatic logic [11:0] model(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    int ua, ub, sa, sb, full, sfull;
    logic c, v, arith;
    logic [7:0] r;
    logic [3:0] f;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    full = 0;
    sfull = 0;
    c = 1'b0;
    arith = 1'b0;
    case (op)
      4'd0:  full = 0;
      4'd1:  begin full = ua + ub; c = (full > 255); sfull = sa + sb; arith = 1'b1; end
      4'd2:  begin full = ua - ub; c = (ua < ub);    sfull = sa - sb; arith = 1'b1; end
      4'd3:  full = ua & ub;
      4'd4:  full = ua | ub;
      4'd5:  full = ua ^ ub;
      4'd6:  begin full = ua + 1; c = (ua == 255); sfull = sa + 1; arith = 1'b1; end
      4'd7:  begin full = ua - 1; c = (ua == 0);   sfull = sa - 1; arith = 1'b1; end
      4'd8:  full = 255 - ua;
      4'd9:  begin full = -ua; c = (ua != 0); sfull = -sa; arith = 1'b1; end
      4'd10: begin full = ua / 2; c = (ua % 2 == 1); end
      4'd11: begin full = ua * 2; c = (ua >= 128); end
      4'd12: begin full = ua / 2 + (ua % 2) * 128; c = (ua % 2 == 1); end
      4'd13: begin full = ua * 2 + ua / 128; c = (ua >= 128); end
      default: return 12'h000;
    endcase
    r = full[7:0];
    v = arith && ((sfull > 127) || (sfull < -128));
    f = {r[7], v, c, (r == 8'h00)};
`ifndef ALU_FLAGS_EN
    f = 4'b0000;
`endif
    return {r, f};
  endfunction

  task automatic checkOutput(input string tag, input logic exp_valid);
    vectors++;
    assert (bus.out_valid === exp_valid) else begin
      miscompares++;
      $error("FAIL %s out_valid: observed %b expected %b", tag, bus.out_valid, exp_valid);
    end
    vectors++;
    assert (bus.result === exp_result) else begin
      miscompares++;
      $error("FAIL %s result: observed %h expected %h", tag, bus.result, exp_result);
    end
    vectors++;
    assert (bus.flags === exp_flags) else begin
      miscompares++;
      $error("FAIL %s flags: observed %b expected %b", tag, bus.flags, exp_flags);
    end
  endtask

  // Literal values straight from the operation table, independent of the model.
  task automatic checkLiteral(input string tag, input logic [7:0] res, input logic [3:0] flg);
    logic [3:0] f;
    f = flg;
`ifndef ALU_FLAGS_EN
    f = 4'b0000;
`endif
    vectors++;
    assert (bus.result === res && bus.flags === f) else begin
      miscompares++;
      $error("FAIL %s literal: observed %h/%b expected %h/%b", tag, bus.result, bus.flags, res, f);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic valid, input logic [3:0] op,
                               input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.in_valid = valid;
    bus.opcode   = op;
    bus.operandA = a;
    bus.operandB = b;
    if (valid) {exp_result, exp_flags} = model(op, a, b);
    @(posedge clk);
    #1;
    checkOutput(tag, valid);
  endtask

  initial begin
    logic       rvalid;
    logic [3:0] rop;
    logic [7:0] ra, rb;

    $display("[TB] alu_core bench starting");
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.opcode   = OP_ADD;
    bus.operandA = 8'h05;
    bus.operandB = 8'h03;
    exp_result   = 8'h00;
    exp_flags    = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0);

    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;

    applyStimulus("idle_after_reset", 1'b0, OP_ADD, 8'h11, 8'h22);

    applyStimulus("add_5_3", 1'b1, OP_ADD, 8'h05, 8'h03);   checkLiteral("add_5_3", 8'h08, 4'b0000);
    applyStimulus("sub_5_3", 1'b1, OP_SUB, 8'h05, 8'h03);   checkLiteral("sub_5_3", 8'h02, 4'b0000);
    applyStimulus("sub_3_5", 1'b1, OP_SUB, 8'h03, 8'h05);   checkLiteral("sub_3_5", 8'hFE, 4'b1010);
    applyStimulus("add_7f_1", 1'b1, OP_ADD, 8'h7F, 8'h01);  checkLiteral("add_7f_1", 8'h80, 4'b1100);
    applyStimulus("and", 1'b1, OP_AND, 8'h0F, 8'hF0);       checkLiteral("and", 8'h00, 4'b0001);
    applyStimulus("or", 1'b1, OP_OR, 8'h0F, 8'hF0);         checkLiteral("or", 8'hFF, 4'b1000);
    applyStimulus("xor", 1'b1, OP_XOR, 8'h0F, 8'hF0);       checkLiteral("xor", 8'hFF, 4'b1000);
    applyStimulus("not", 1'b1, OP_NOT, 8'hAA, 8'h00);       checkLiteral("not", 8'h55, 4'b0000);
    applyStimulus("inc", 1'b1, OP_INC, 8'h05, 8'h00);       checkLiteral("inc", 8'h06, 4'b0000);
    applyStimulus("dec", 1'b1, OP_DEC, 8'h05, 8'h00);       checkLiteral("dec", 8'h04, 4'b0000);
    applyStimulus("neg", 1'b1, OP_NEG, 8'h05, 8'h00);       checkLiteral("neg", 8'hFB, 4'b1010);
    applyStimulus("inc_ff", 1'b1, OP_INC, 8'hFF, 8'h00);    checkLiteral("inc_ff", 8'h00, 4'b0011);
    applyStimulus("dec_00", 1'b1, OP_DEC, 8'h00, 8'h00);    checkLiteral("dec_00", 8'hFF, 4'b1010);
    applyStimulus("neg_80", 1'b1, OP_NEG, 8'h80, 8'h00);    checkLiteral("neg_80", 8'h80, 4'b1110);
    applyStimulus("shr", 1'b1, OP_SHR, 8'hAA, 8'h00);       checkLiteral("shr", 8'h55, 4'b0000);
    applyStimulus("shl", 1'b1, OP_SHL, 8'hAA, 8'h00);       checkLiteral("shl", 8'h54, 4'b0010);
    applyStimulus("ror", 1'b1, OP_ROR, 8'hAA, 8'h00);       checkLiteral("ror", 8'h55, 4'b0000);
    applyStimulus("rol", 1'b1, OP_ROL, 8'hAA, 8'h00);       checkLiteral("rol", 8'h55, 4'b0010);
    applyStimulus("idle_hold", 1'b0, OP_ADD, 8'h01, 8'h01); checkLiteral("idle_hold", 8'h55, 4'b0010);
    applyStimulus("nop", 1'b1, OP_NOP, 8'h12, 8'h34);       checkLiteral("nop", 8'h00, 4'b0001);
    applyStimulus("add_ff_ff", 1'b1, OP_ADD, 8'hFF, 8'hFF); checkLiteral("add_ff_ff", 8'hFE, 4'b1010);
    applyStimulus("rsv_e", 1'b1, OP_RSV0, 8'hFF, 8'hFF);    checkLiteral("rsv_e", 8'h00, 4'b0000);
    applyStimulus("rsv_f", 1'b1, OP_RSV1, 8'h80, 8'h01);    checkLiteral("rsv_f", 8'h00, 4'b0000);

    // Reset must win over a valid operation and clear a non-zero result.
    applyStimulus("pre_reset", 1'b1, OP_SUB, 8'h03, 8'h05);
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.opcode   = OP_ADD;
    bus.operandA = 8'h7F;
    bus.operandB = 8'h01;
    @(posedge clk);
    #1;
    exp_result = 8'h00;
    exp_flags  = 4'b0000;
    checkOutput("reset_mid", 1'b0);
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;

    for (int i = 0; i < 200; i++) begin
      rvalid = ($urandom_range(0, 4) != 0);
      rop    = 4'($urandom_range(0, 15));
      ra     = 8'($urandom);
      rb     = 8'($urandom);
      applyStimulus($sformatf("rand%0d_op%0d", i, rop), rvalid, rop, ra, rb);
    end

    @(negedge clk);
    bus.in_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
